stopwatch_counter: RTL and testbench

- Sequential mm:ss stopwatch core that sits directly upstream of the binary-to-two-digit seven-segment decoder.
- Divides the board clock into a 1 Hz tick and runs a start/pause/clear state machine.
- Produces 6-bit binary seconds and minutes (0-59 each). Each output feeds one decoder instance (HEX_0/HEX_1 for seconds, HEX_2/HEX_3 for minutes).

---
 rtl/stopwatch_counter_pkg.sv | 14 +
 rtl/stopwatch_counter_btn_edge_sync.sv | 35 +++
 rtl/stopwatch_counter.sv | 115 +++++++++++
 tb/tb_stopwatch_counter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the mm:ss stopwatch core.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int SEC_W            = 6;
  localparam int MIN_W            = 6;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/stopwatch_counter_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for one raw pushbutton.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic edge_pulse
);

  logic       sync0;
  logic       sync1;
  logic       prev;
  logic [1:0] warm;
  logic       armed;

  // armed only sets once sync1 has shown the button low after reset,
  // so a button held through reset never produces an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
      warm  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      prev  <= sync1;
      warm  <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & ~sync1);
    end
  end

  assign edge_pulse = sync1 & ~prev & armed;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: 1 Hz prescaler, start/pause/clear FSM and mm:ss counters.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int MAX_SEC  = 59,
  parameter int MAX_MIN  = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start_stop,
  input  logic             btn_clear,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic             running,
  output logic             tick,
  output logic             rollover
);

  localparam int             PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_t        state, state_n;
  logic [PRE_W-1:0] prescaler, prescaler_n;
  logic [SEC_W-1:0] seconds_n;
  logic [MIN_W-1:0] minutes_n;
  logic             tick_n;
  logic             rollover_n;
  logic             ss_edge;
  logic             clr_edge;

  btn_edge_sync u_ss_sync (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_start_stop),
    .edge_pulse (ss_edge)
  );

  btn_edge_sync u_clr_sync (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_clear),
    .edge_pulse (clr_edge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      seconds   <= '0;
      minutes   <= '0;
      running   <= 1'b0;
      tick      <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      seconds   <= seconds_n;
      minutes   <= minutes_n;
      running   <= (state_n == RUN);
      tick      <= tick_n;
      rollover  <= rollover_n;
    end
  end

  // Clear overrides everything, including a coincident tick or start_stop.
  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    seconds_n   = seconds;
    minutes_n   = minutes;
    tick_n      = 1'b0;
    rollover_n  = 1'b0;
    if (clr_edge) begin
      state_n     = IDLE;
      prescaler_n = '0;
      seconds_n   = '0;
      minutes_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          prescaler_n = '0;
          seconds_n   = '0;
          minutes_n   = '0;
          if (ss_edge) state_n = RUN;
        end
        RUN: begin
          if (prescaler == PRE_LAST) begin
            prescaler_n = '0;
            tick_n      = 1'b1;
            if (seconds == SEC_W'(MAX_SEC)) begin
              seconds_n = '0;
              if (minutes == MIN_W'(MAX_MIN)) begin
                minutes_n  = '0;
                rollover_n = 1'b1;
              end else begin
                minutes_n = minutes + 1'b1;
              end
            end else begin
              seconds_n = seconds + 1'b1;
            end
          end else begin
            prescaler_n = prescaler + 1'b1;
          end
          if (ss_edge) state_n = PAUSE;
        end
        PAUSE: begin
          if (ss_edge) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter with TICK_DIV=4.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       running;
  logic       tick;
  logic       rollover;

  int checks = 0;
  int fails  = 0;

  logic [14:0] obs;
  logic [14:0] e;
  assign obs = {minutes, seconds, running, tick, rollover};

  stopwatch_counter #(
    .TICK_DIV (4),
    .MAX_SEC  (59),
    .MAX_MIN  (59)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .seconds        (seconds),
    .minutes        (minutes),
    .running        (running),
    .tick           (tick),
    .rollover       (rollover)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Input set before edge X; its effect is visible after edge X+2.
  task automatic press(input logic ss, input logic clr, input logic hold);
    btn_start_stop = ss;
    btn_clear      = clr;
    step(2);
    if (!hold) begin
      btn_start_stop = 1'b0;
      btn_clear      = 1'b0;
    end
    step(1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL reset_state: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    rst = 1'b0;
    step(6);
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL reset_idle_no_count: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
  endtask

  task automatic test_start_latency;
    btn_start_stop = 1'b1;
    step(2);
    btn_start_stop = 1'b0;
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL start_not_early: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(1);
    e = {6'd0, 6'd0, 3'b100};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL start_running: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(3);
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL start_no_early_tick: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(1);
    e = {6'd0, 6'd1, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL start_first_tick: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(16);
    e = {6'd0, 6'd5, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL start_20_clocks: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
  endtask

  task automatic test_pause_resume;
    logic tick_seen;
    logic sec_moved;
    step(3);
    press(1'b1, 1'b0, 1'b0);
    e = {6'd0, 6'd6, 3'b000};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL pause_enter: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    tick_seen = 1'b0;
    sec_moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tick === 1'b1) tick_seen = 1'b1;
      if (seconds !== 6'd6) sec_moved = 1'b1;
    end
    checks++;
    if (tick_seen !== 1'b0) begin fails++; $display("[TB] FAIL pause_no_tick: got %b expected 0", tick_seen); end
    checks++;
    if (sec_moved !== 1'b0) begin fails++; $display("[TB] FAIL pause_hold_seconds: got %0d expected 6", seconds); end
    press(1'b1, 1'b0, 1'b0);
    step(1);
    e = {6'd0, 6'd6, 3'b100};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL resume_partial_kept: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(1);
    e = {6'd0, 6'd7, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL resume_tick: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
  endtask

  task automatic test_reset_mid_run;
    step(1);
    #2;
    rst = 1'b1;
    btn_start_stop = 1'b1;
    #1;
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL reset_async: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(3);
    rst = 1'b0;
    step(12);
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL reset_held_button: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    btn_start_stop = 1'b0;
    step(5);
  endtask

  task automatic test_wrap;
    press(1'b1, 1'b0, 1'b0);
    step(239);
    e = {6'd0, 6'd59, 3'b100};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL wrap_pre_minute: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(1);
    e = {6'd1, 6'd0, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL wrap_minute: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(14156);
    e = {6'd59, 6'd59, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL wrap_5959: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(4);
    e = {6'd0, 6'd0, 3'b111};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL wrap_rollover: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(1);
    e = {6'd0, 6'd0, 3'b100};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL wrap_rollover_one_cycle: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
  endtask

  task automatic test_clear_priority;
    press(1'b0, 1'b1, 1'b0);
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL clear_from_run: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    press(1'b1, 1'b0, 1'b0);
    step(768);
    e = {6'd3, 6'd12, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL clear_reach_0312: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    press(1'b1, 1'b1, 1'b1);
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL clear_beats_start: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    btn_clear = 1'b0;
    step(20);
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL clear_held_start_no_edge: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    btn_start_stop = 1'b0;
    step(4);
  endtask

  task automatic test_clear_vs_tick;
    press(1'b1, 1'b0, 1'b0);
    step(5);
    e = {6'd0, 6'd1, 3'b100};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL cvt_before: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    press(1'b0, 1'b1, 1'b0);
    e = 15'd0;
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL cvt_clear_wins: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(3);
  endtask

  task automatic test_tick_and_pause;
    press(1'b1, 1'b0, 1'b0);
    step(1);
    press(1'b1, 1'b0, 1'b0);
    e = {6'd0, 6'd1, 3'b010};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL tap_increment_then_pause: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    step(20);
    e = {6'd0, 6'd1, 3'b000};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL tap_paused_hold: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
    press(1'b1, 1'b0, 1'b0);
    step(4);
    e = {6'd0, 6'd2, 3'b110};
    checks++;
    if (obs !== e) begin fails++; $display("[TB] FAIL tap_resume_full_second: got %0d:%0d rto=%b expected %0d:%0d rto=%b", obs[14:9], obs[8:3], obs[2:0], e[14:9], e[8:3], e[2:0]); end
  endtask

  initial begin
    test_reset;
    test_start_latency;
    test_pause_resume;
    test_reset_mid_run;
    test_wrap;
    test_clear_priority;
    test_clear_vs_tick;
    test_tick_and_pause;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
